scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_sequencer_dwell_timer.sv | 27 ++
 rtl/scan_sequencer.sv | 134 +++++++++++++
 tb/tb_scan_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: code width and FSM state encoding.
package scan_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_WAIT_STEP = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/scan_sequencer_dwell_timer.sv
// Per-code hold counter: loads a dwell value, counts down to zero, flags expiry at zero.
module dwell_timer
    import scan_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [CODE_W-1:0] load_val,
    input  logic              dec,
    output logic              expired
);

    logic [CODE_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 4-bit decoder select code from first to last (mod 16), holding each
// code dwell+1 cycles, in auto-advance or single-step mode, with optional looping.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int LOOP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step_mode,
    input  logic              step,
    input  logic [CODE_W-1:0] first,
    input  logic [CODE_W-1:0] last,
    input  logic [CODE_W-1:0] dwell,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              busy,
    output logic              done
);

    state_t            state, state_n;
    logic [CODE_W-1:0] code_n;
    logic [CODE_W-1:0] first_q, last_q, dwell_q;
    logic              mode_q;
    logic              capture;
    logic              adv;
    logic              ld;
    logic [CODE_W-1:0] ld_val;
    logic              dec;
    logic              expired;
    logic              vld_n;

    dwell_timer u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .dec      (dec),
        .expired  (expired)
    );

    always_comb begin
        state_n = state;
        code_n  = code;
        capture = 1'b0;
        adv     = 1'b0;
        ld      = 1'b0;
        ld_val  = dwell_q;
        dec     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    capture = 1'b1;
                    state_n = ST_ACTIVE;
                    code_n  = first;
                    ld      = 1'b1;
                    ld_val  = dwell;
                end
            end
            ST_ACTIVE: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (expired) begin
                    if (mode_q) begin
                        state_n = ST_WAIT_STEP;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    dec = 1'b1;
                end
            end
            ST_WAIT_STEP: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (step) begin
                    adv = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Leaving a code: either move to the next one, wrap back to first, or finish.
        if (adv) begin
            if (code == last_q) begin
                if (LOOP != 0) begin
                    state_n = ST_ACTIVE;
                    code_n  = first_q;
                    ld      = 1'b1;
                end else begin
                    state_n = ST_DONE;
                end
            end else begin
                state_n = ST_ACTIVE;
                code_n  = code + 1'b1;
                ld      = 1'b1;
            end
        end
    end

    assign vld_n = (state_n == ST_ACTIVE) || (state_n == ST_WAIT_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            code       <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            first_q    <= '0;
            last_q     <= '0;
            dwell_q    <= '0;
            mode_q     <= 1'b0;
        end else begin
            state      <= state_n;
            code       <= code_n;
            code_valid <= vld_n;
            busy       <= vld_n;
            done       <= (state_n == ST_DONE);
            if (capture) begin
                first_q <= first;
                last_q  <= last;
                dwell_q <= dwell;
                mode_q  <= step_mode;
            end
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: one non-looping and one looping instance.
module tb_scan_sequencer;

    logic       clk;
    logic       reset;
    logic       start, stop, start_l, stop_l;
    logic       step_mode, step;
    logic [3:0] first, last, dwell;
    logic [3:0] code, code_l;
    logic       code_valid, busy, done;
    logic       code_valid_l, busy_l, done_l;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] wrap_seq [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

    scan_sequencer #(.LOOP(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .step_mode  (step_mode),
        .step       (step),
        .first      (first),
        .last       (last),
        .dwell      (dwell),
        .code       (code),
        .code_valid (code_valid),
        .busy       (busy),
        .done       (done)
    );

    scan_sequencer #(.LOOP(1)) dut_loop (
        .clk        (clk),
        .reset      (reset),
        .start      (start_l),
        .stop       (stop_l),
        .step_mode  (step_mode),
        .step       (step),
        .first      (first),
        .last       (last),
        .dwell      (dwell),
        .code       (code_l),
        .code_valid (code_valid_l),
        .busy       (busy_l),
        .done       (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, " vld"},  code_valid, 0);
        check_val({tag, " busy"}, busy, 0);
        check_val({tag, " done"}, done, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; start_l = 1'b0; stop_l = 1'b0;
        step_mode = 1'b0; step = 1'b0; first = '0; last = '0; dwell = '0;

        // reset state
        repeat (2) tick();
        check_val("rst code", code, 0);
        check_idle("rst");
        check_val("rst loop vld", code_valid_l, 0);
        reset = 1'b0;
        tick();
        check_idle("post-rst");

        // auto mode 3..6, dwell 0
        first = 4'd3; last = 4'd6; dwell = 4'd0; step_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("A code", code, 3 + i);
            check_val("A vld", code_valid, 1);
            check_val("A busy", busy, 1);
            check_val("A done", done, 0);
            tick();
        end
        check_val("A done pulse", done, 1);
        check_val("A done vld", code_valid, 0);
        check_val("A done busy", busy, 0);
        check_val("A code hold", code, 6);
        tick();
        check_val("A done end", done, 0);
        check_val("A idle code", code, 6);

        // wrap 14..1, dwell 2; inputs changed and start re-asserted mid-scan
        first = 4'd14; last = 4'd1; dwell = 4'd2; start = 1'b1;
        tick();
        first = 4'd5; last = 4'd5; dwell = 4'd0;
        for (int i = 0; i < 12; i++) begin
            check_val("B code", code, wrap_seq[i / 3]);
            check_val("B vld", code_valid, 1);
            start = 1'b0;
            tick();
        end
        check_val("B done pulse", done, 1);
        check_val("B done vld", code_valid, 0);
        tick();
        check_val("B done end", done, 0);

        // step mode 0..2, dwell 1
        first = 4'd0; last = 4'd2; dwell = 4'd1; step_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        step_mode = 1'b0;
        check_val("C code0", code, 0);
        step = 1'b1;
        tick();
        check_val("C early step ignored", code, 0);
        step = 1'b0;
        tick();
        check_val("C wait code", code, 0);
        check_val("C wait vld", code_valid, 1);
        check_val("C wait busy", busy, 1);
        tick();
        check_val("C wait hold", code, 0);
        for (int c = 1; c <= 2; c++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            check_val("C step code", code, c);
            tick();
            tick();
            check_val("C wait code n", code, c);
            check_val("C no done", done, 0);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check_val("C done pulse", done, 1);
        check_val("C done vld", code_valid, 0);
        tick();
        check_val("C done end", done, 0);

        // stop at code 5 of 0..9
        first = 4'd0; last = 4'd9; dwell = 4'd0; step_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check_val("D at 5", code, 5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("D stop");
        for (int i = 0; i < 8; i++) begin
            check_val("D no done", done, 0);
            tick();
        end

        // start together with stop in idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_idle("E start+stop");
        tick();
        check_val("E still idle", busy, 0);

        // asynchronous reset mid-scan
        first = 4'd4; last = 4'd8; dwell = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("F code", code, 4);
        check_val("F vld", code_valid, 1);
        reset = 1'b1;
        #1;
        check_val("F async code", code, 0);
        check_val("F async vld", code_valid, 0);
        check_val("F async busy", busy, 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        check_idle("F after rst");

        // looping instance 2,3,2,3,...
        first = 4'd2; last = 4'd3; dwell = 4'd0; start_l = 1'b1;
        tick();
        start_l = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_val("G code", code_l, (i % 2 == 0) ? 2 : 3);
            check_val("G vld", code_valid_l, 1);
            check_val("G no done", done_l, 0);
            tick();
        end
        stop_l = 1'b1;
        tick();
        stop_l = 1'b0;
        check_val("G stop vld", code_valid_l, 0);
        check_val("G stop busy", busy_l, 0);
        check_val("G stop done", done_l, 0);
        tick();
        check_val("G stop done2", done_l, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
